serial_adder_ctrl: RTL and testbench
====================================

# serial_adder_ctrl

Bit-serial adder controller. It time-shares a single `Full_Adder` cell across an N-bit addition, one bit per clock, LSB first. It sequences operand shifting, carry feedback and result assembly, and presents a start/busy/done handshake to the surrounding logic. It is the area-minimal alternative to the ripple-carry adder in the arithmetic labs.

## Interface
Parameters:
- `N`, default 8, operand width in bits; legal range 2..32.
- `CW`, default $clog2(N), bit-counter width.

Ports (one clock; reset is asynchronous and active-high):
- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request an addition; sampled only in IDLE.
- `a` input N: operand A; captured on the accepted start edge.
- `b` input N: operand B; captured on the accepted start edge.
- `cin` input 1: carry-in; captured on the accepted start edge.
- `busy` output 1: high in RUN and DONE.
- `done` output 1: single-cycle pulse; result valid from this cycle.
- `sum` output N: result; holds until the next accepted start.
- `cout` output 1: carry-out of the MSB.
- `ovf` output 1: signed overflow, equal to carry into MSB XOR carry out of MSB.

## Operation
- FSM states: IDLE, RUN, DONE. Encoding is free.
- IDLE with `start`=1 at an edge:
  - Capture a→a_sh, b→b_sh, cin→c_reg.
  - Set cnt←0 and clear sum_sh.
  - Next state RUN.
- IDLE with `start`=0: stay in IDLE.
- RUN, at every edge:
  - Exactly one instantiated `Full_Adder` computes (a_sh[0], b_sh[0], c_reg) → (s, co).
  - Shift sum_sh right and insert s at bit N-1.
  - Shift a_sh and b_sh right by one.
  - c_reg←co; cnt←cnt+1.
  - When cnt==N-2, latch c_msb_in←co. This is the carry into the MSB.
  - When cnt==N-1, load `sum`←{s, sum_sh[N-1:1]}, `cout`←co, `ovf`←c_msb_in^co, and go to DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE unconditionally.
- `start` while in RUN or DONE is ignored and not queued. `a`/`b`/`cin` changes after capture have no effect on the result.
- Arithmetic is modulo 2^N with `cout` as bit N. `ovf` treats `a`, `b` and `sum` as two's complement.
- Reset, asynchronous and valid in any state, including mid-RUN:
  - State→IDLE.
  - `busy`=0, `done`=0, `sum`=0, `cout`=0, `ovf`=0.
  - Shift registers, c_reg and cnt cleared.
  - The in-flight operation is discarded; no `done` is produced for it.
- `done` never asserts except by exiting RUN.

## Timing
- Start accepted at edge E0. State is RUN after E0; bit i is processed at edge E0+1+i.
- At edge E0+N the state becomes DONE. `done`=1 and `sum`/`cout`/`ovf` are valid during the cycle following E0+N.
- At edge E0+N+1 the state returns to IDLE.
- Start-to-done latency is N cycles. Back-to-back throughput is one operation per N+2 cycles, because start is sampled in IDLE only. With `start` held high, the next capture happens at E0+N+2.
- `busy` rises in the cycle after E0 and falls in the cycle after E0+N+1.
- All outputs are registered; no combinational path from inputs to outputs.
- If reset is released while `start`=1, the start is accepted at the first rising edge after release.

## Test plan
- Reset then idle: assert `rst` mid-stream, release, hold `start`=0 for 20 cycles → `busy`=0, `done`=0, `sum`=0, `cout`=0, `ovf`=0 throughout.
- Basic add, N=8: a=8'h5A, b=8'h3C, cin=0, start pulse → `done` exactly 8 cycles after the start edge; `sum`=8'h96, `cout`=0, `ovf`=1.
- Carry chain and carry-in:
  - a=8'hFF, b=8'h01, cin=0 → `sum`=8'h00, `cout`=1, `ovf`=0.
  - a=8'h00, b=8'h00, cin=1 → `sum`=8'h01, `cout`=0, `ovf`=0.
- Signed overflow: a=8'h80, b=8'h80, cin=0 → `sum`=8'h00, `cout`=1, `ovf`=1.
- Handshake robustness:
  - Toggle `start`, `a` and `b` every cycle during RUN → result equals the captured operands only, single `done` pulse.
  - `start` held high → captures every 10 cycles.
- Mid-operation reset: assert `rst` at bit 4 of an 8-bit add, then start a=8'h12, b=8'h34 → no `done` for the aborted op; new result `sum`=8'h46 after 8 cycles. Also run random regression of 1000 ops against a+b+cin.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// One-bit full adder cell, time-shared by the serial adder below.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the cell has no handshake.
module Full_Adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// Bit-serial N-bit adder: one Full_Adder cell, one bit per clock, LSB first.
// Latency: N cycles from the accepted start edge to the done pulse; N+2 per op back-to-back.
// Backpressure: start is only sampled in IDLE; requests during RUN/DONE are dropped, never queued.
module serial_adder_ctrl #(
    parameter int N  = 8,
    parameter int CW = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Operand shifters; bit 0 is the bit being added this cycle.
    logic [N-1:0]  a_sh;
    logic [N-1:0]  b_sh;
    // Partial result. Only N-1 bits are stored: the MSB produced on the
    // last cycle goes straight into sum together with this register.
    logic [N-2:0]  sum_sh;
    logic          c_reg;
    logic          c_msb_in;
    logic [CW-1:0] cnt;

    logic          fa_s;
    logic          fa_co;
    logic [N-1:0]  sum_cat;
    logic          accept;
    logic          msb_minus1;
    logic          last_bit;

    Full_Adder u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (c_reg),
        .s  (fa_s),
        .co (fa_co)
    );

    // The new sum bit enters at the top of the window; the full window is the final result.
    assign sum_cat    = {fa_s, sum_sh};
    assign accept     = (state == IDLE) && start;
    assign msb_minus1 = (state == RUN) && (cnt == CW'(N - 2));
    assign last_bit   = (state == RUN) && (cnt == CW'(N - 1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: IDLE waits for start, RUN counts N bits, DONE lasts one cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == CW'(N - 1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs registered from the next state so they line up with the state itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_nxt == RUN) || (state_nxt == DONE);
            done <= (state_nxt == DONE);
        end
    end

    // Datapath: capture operands on accept, then shift one bit through the adder per RUN cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh     <= '0;
            b_sh     <= '0;
            sum_sh   <= '0;
            c_reg    <= 1'b0;
            c_msb_in <= 1'b0;
            cnt      <= '0;
        end else if (accept) begin
            a_sh     <= a;
            b_sh     <= b;
            sum_sh   <= '0;
            c_reg    <= cin;
            c_msb_in <= 1'b0;
            cnt      <= '0;
        end else if (state == RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            sum_sh <= sum_cat[N-1:1];
            c_reg  <= fa_co;
            cnt    <= cnt + CW'(1);
            if (msb_minus1) begin
                c_msb_in <= fa_co;
            end
        end
    end

    // Result registers: loaded on the MSB cycle and held until the next run completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum  <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
        end else if (last_bit) begin
            sum  <= sum_cat;
            cout <= fa_co;
            ovf  <= c_msb_in ^ fa_co;
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;

    localparam int N = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;

    int n_chk;
    int n_bad;

    serial_adder_ctrl #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One addition with start pulse; checks busy, latency, result and return to idle.
    task automatic run_op(input string tag, input logic [7:0] xa, input logic [7:0] xb,
                          input logic xc, input logic [7:0] es, input logic ec, input logic eo);
        int lat;
        bit got;
        a = xa; b = xb; cin = xc; start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_busy_run"}, 32'(busy), 32'd1);
        chk({tag, "_done_early"}, 32'(done), 32'd0);
        lat = 0;
        got = 0;
        while (!got && lat < 20) begin
            tick();
            lat++;
            if (done) got = 1;
        end
        chk({tag, "_lat"}, lat, 8);
        chk({tag, "_sum"}, 32'(sum), 32'(es));
        chk({tag, "_cout"}, 32'(cout), 32'(ec));
        chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
        tick();
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
        chk({tag, "_sum_hold"}, 32'(sum), 32'(es));
    endtask

    initial begin
        logic [8:0] tot;
        logic [7:0] ra, rb;
        logic       rc;
        int         ndone;
        int         gap;
        logic [7:0] cap_sum;

        n_chk = 0;
        n_bad = 0;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        tick();
        chk("rst_state", {busy, done, cout, ovf, sum}, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Directed vectors
        run_op("basic", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
        run_op("carry", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op("cin",   8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);
        run_op("sovf",  8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
        run_op("pos",   8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);

        // Reset mid-stream, then idle for 20 cycles
        a = 8'h33; b = 8'h44; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        rst = 1'b1;
        #1;
        chk("rst_async", {busy, done, cout, ovf, sum}, 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle20", {busy, done, cout, ovf, sum}, 32'd0);
        end

        // Toggle start/a/b during RUN: result uses the captured operands, one done pulse
        a = 8'h21; b = 8'h43; cin = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        ndone = 0;
        cap_sum = 8'h00;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (done) begin ndone++; cap_sum = sum; end
            start = ~start; a = ~a; b = b + 8'h11; cin = ~cin;
        end
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) begin ndone++; cap_sum = sum; end
        end
        chk("tog_ndone", ndone, 1);
        chk("tog_sum", 32'(cap_sum), 32'h65);
        chk("tog_cout", 32'(cout), 32'd0);

        // start held high: one capture every N+2 cycles
        a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
        gap = 0;
        while (!done && gap < 20) begin tick(); gap++; end
        chk("hold_first", gap, 9);
        for (int k = 0; k < 2; k++) begin
            gap = 0;
            tick();
            gap++;
            while (!done && gap < 30) begin tick(); gap++; end
            chk("hold_period", gap, 10);
            chk("hold_sum", 32'(sum), 32'h03);
        end
        start = 1'b0;
        tick(); tick();
        chk("hold_stop", 32'(busy), 32'd0);

        // Reset at bit 4 of an add, no done for it, then a fresh add
        a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        tick();
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) ndone++;
        end
        chk("mid_rst_nodone", ndone, 0);
        chk("mid_rst_sum", 32'(sum), 32'd0);
        run_op("after_rst", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);

        // Random regression against a + b + cin
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            tot = 9'(ra) + 9'(rb) + 9'(rc);
            run_op("rand", ra, rb, rc, tot[7:0], tot[8],
                   (ra[7] == rb[7]) && (tot[7] != ra[7]));
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
